// File: rtl/upc_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// upc_ctrl_pkg
// Shared type definitions for the UPC checkout sequencing controller.
//   state_t : controller FSM state encoding (IDLE, SETTLE, DECIDE, ALARM)
// ----------------------------------------------------------------------------
package upc_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    DECIDE = 2'd2,
    ALARM  = 2'd3
  } state_t;

  // Width of the settle-window counter; covers SETTLE_CYCLES up to 15.
  localparam int unsigned SETTLE_W = 4;

endpackage : upc_ctrl_pkg

// File: rtl/edge_det.sv
// ----------------------------------------------------------------------------
// edge_det
// Rising-edge detector on an already-synchronized level input. The previous
// sample resets to 1 so that a level held high across reset release does not
// look like a fresh press.
// Ports:
//   i_clk     : system clock
//   i_reset_n : synchronous active-low reset
//   i_level   : synchronized level input
//   o_edge    : high for the cycle in which i_level rises
// ----------------------------------------------------------------------------
module edge_det (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_level,
  output logic o_edge
);

  logic r_prev;

  // Previous-sample register, updated every cycle.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_prev <= 1'b1;
    end else begin
      r_prev <= i_level;
    end
  end

  assign o_edge = i_level & ~r_prev;

endmodule : edge_det

// File: rtl/upc_checkout_ctrl.sv
// ----------------------------------------------------------------------------
// upc_checkout_ctrl
// Turns scan / clear button presses into single checkout transactions for the
// combinational UPC checker: latches the item code, waits a settle window,
// samples the verdict, keeps saturating per-session tallies and holds a theft
// alarm until acknowledged.
// Ports:
//   i_clk, i_reset_n         : clock, synchronous active-low reset
//   i_scan_btn, i_clr_btn    : scan request / alarm acknowledge levels
//   i_new_sess               : clear tallies (IDLE only)
//   i_upc, i_mark            : item code and security mark from switches
//   i_discounted_in/i_stolen_in : verdict from the UPC checker
//   o_upc_q, o_mark_q        : latched item driven to checker and display
//   o_busy, o_alarm          : status (not IDLE / in ALARM)
//   o_last_disc              : verdict of the last accepted item
//   o_item_cnt, o_disc_cnt, o_stolen_cnt : saturating tallies
// ----------------------------------------------------------------------------
module upc_checkout_ctrl
  import upc_ctrl_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned CNT_W         = 4
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_scan_btn,
  input  logic             i_clr_btn,
  input  logic             i_new_sess,
  input  logic [2:0]       i_upc,
  input  logic             i_mark,
  input  logic             i_discounted_in,
  input  logic             i_stolen_in,
  output logic [2:0]       o_upc_q,
  output logic             o_mark_q,
  output logic             o_busy,
  output logic             o_alarm,
  output logic             o_last_disc,
  output logic [CNT_W-1:0] o_item_cnt,
  output logic [CNT_W-1:0] o_disc_cnt,
  output logic [CNT_W-1:0] o_stolen_cnt
);

  localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES - 1);
  localparam logic [SETTLE_W-1:0] SETTLE_ONE  = {{(SETTLE_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]    CNT_ZERO    = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]    CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]    CNT_MAX     = {CNT_W{1'b1}};

  // Tallies stick at full scale rather than wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : (v + CNT_ONE);
  endfunction

  state_t              r_state,      w_state_nxt;
  logic [SETTLE_W-1:0] r_settle_cnt, w_settle_nxt;
  logic [2:0]          r_upc_q,      w_upc_nxt;
  logic                r_mark_q,     w_mark_nxt;
  logic                r_last_disc,  w_last_disc_nxt;
  logic [CNT_W-1:0]    r_item_cnt,   w_item_nxt;
  logic [CNT_W-1:0]    r_disc_cnt,   w_disc_nxt;
  logic [CNT_W-1:0]    r_stolen_cnt, w_stolen_nxt;
  logic                r_busy;
  logic                r_alarm;
  logic                w_scan_edge;
  logic                w_clr_edge;

  edge_det u_scan_edge (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_level   (i_scan_btn),
    .o_edge    (w_scan_edge)
  );

  edge_det u_clr_edge (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_level   (i_clr_btn),
    .o_edge    (w_clr_edge)
  );

  // Next-state and next-datapath logic; events not legal in a state are dropped.
  always_comb begin
    w_state_nxt     = r_state;
    w_settle_nxt    = r_settle_cnt;
    w_upc_nxt       = r_upc_q;
    w_mark_nxt      = r_mark_q;
    w_last_disc_nxt = r_last_disc;
    w_item_nxt      = r_item_cnt;
    w_disc_nxt      = r_disc_cnt;
    w_stolen_nxt    = r_stolen_cnt;
    case (r_state)
      IDLE: begin
        // A scan in the same cycle as new_sess takes priority.
        if (w_scan_edge) begin
          w_upc_nxt    = i_upc;
          w_mark_nxt   = i_mark;
          w_settle_nxt = {SETTLE_W{1'b0}};
          w_state_nxt  = SETTLE;
        end else if (i_new_sess) begin
          w_item_nxt      = CNT_ZERO;
          w_disc_nxt      = CNT_ZERO;
          w_stolen_nxt    = CNT_ZERO;
          w_last_disc_nxt = 1'b0;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      SETTLE: begin
        w_settle_nxt = r_settle_cnt + SETTLE_ONE;
        if (r_settle_cnt == SETTLE_LAST) begin
          w_state_nxt = DECIDE;
        end else begin
          w_state_nxt = SETTLE;
        end
      end
      DECIDE: begin
        if (i_stolen_in) begin
          w_stolen_nxt = sat_inc(r_stolen_cnt);
          w_state_nxt  = ALARM;
        end else begin
          w_item_nxt      = sat_inc(r_item_cnt);
          w_last_disc_nxt = i_discounted_in;
          if (i_discounted_in) begin
            w_disc_nxt = sat_inc(r_disc_cnt);
          end else begin
            w_disc_nxt = r_disc_cnt;
          end
          w_state_nxt = IDLE;
        end
      end
      ALARM: begin
        if (w_clr_edge) begin
          w_state_nxt = IDLE;
        end else begin
          w_state_nxt = ALARM;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // State and datapath registers; status flags are registered from next state.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      r_state      <= IDLE;
      r_settle_cnt <= {SETTLE_W{1'b0}};
      r_upc_q      <= 3'b000;
      r_mark_q     <= 1'b0;
      r_last_disc  <= 1'b0;
      r_item_cnt   <= CNT_ZERO;
      r_disc_cnt   <= CNT_ZERO;
      r_stolen_cnt <= CNT_ZERO;
      r_busy       <= 1'b0;
      r_alarm      <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_settle_cnt <= w_settle_nxt;
      r_upc_q      <= w_upc_nxt;
      r_mark_q     <= w_mark_nxt;
      r_last_disc  <= w_last_disc_nxt;
      r_item_cnt   <= w_item_nxt;
      r_disc_cnt   <= w_disc_nxt;
      r_stolen_cnt <= w_stolen_nxt;
      r_busy       <= (w_state_nxt != IDLE);
      r_alarm      <= (w_state_nxt == ALARM);
    end
  end

  assign o_upc_q      = r_upc_q;
  assign o_mark_q     = r_mark_q;
  assign o_busy       = r_busy;
  assign o_alarm      = r_alarm;
  assign o_last_disc  = r_last_disc;
  assign o_item_cnt   = r_item_cnt;
  assign o_disc_cnt   = r_disc_cnt;
  assign o_stolen_cnt = r_stolen_cnt;

endmodule : upc_checkout_ctrl

// File: tb/tb_upc_checkout_ctrl.sv
// ----------------------------------------------------------------------------
// tb_upc_checkout_ctrl
// Directed self-checking bench for upc_checkout_ctrl (SETTLE_CYCLES=2, CNT_W=4).
// Inputs change 1 time unit after the rising edge; outputs are checked there.
// ----------------------------------------------------------------------------
module tb_upc_checkout_ctrl;

  logic       clk;
  logic       reset_n;
  logic       scan_btn;
  logic       clr_btn;
  logic       new_sess;
  logic [2:0] upc;
  logic       mark;
  logic       discounted_in;
  logic       stolen_in;
  logic [2:0] upc_q;
  logic       mark_q;
  logic       busy;
  logic       alarm;
  logic       last_disc;
  logic [3:0] item_cnt;
  logic [3:0] disc_cnt;
  logic [3:0] stolen_cnt;

  int n_vec;
  int n_fail;

  upc_checkout_ctrl #(
    .SETTLE_CYCLES (2),
    .CNT_W         (4)
  ) dut (
    .i_clk           (clk),
    .i_reset_n       (reset_n),
    .i_scan_btn      (scan_btn),
    .i_clr_btn       (clr_btn),
    .i_new_sess      (new_sess),
    .i_upc           (upc),
    .i_mark          (mark),
    .i_discounted_in (discounted_in),
    .i_stolen_in     (stolen_in),
    .o_upc_q         (upc_q),
    .o_mark_q        (mark_q),
    .o_busy          (busy),
    .o_alarm         (alarm),
    .o_last_disc     (last_disc),
    .o_item_cnt      (item_cnt),
    .o_disc_cnt      (disc_cnt),
    .o_stolen_cnt    (stolen_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One full non-alarm transaction: scan edge, then three more edges so the
  // verdict is folded into the tallies and the FSM is back in IDLE.
  task automatic do_scan();
    scan_btn = 1'b1;
    tick();
    scan_btn = 1'b0;
    tick();
    tick();
    tick();
  endtask

  initial begin
    n_vec = 0;
    n_fail = 0;
    reset_n = 1'b0;
    scan_btn = 1'b1;
    clr_btn = 1'b0;
    new_sess = 1'b0;
    upc = 3'b000;
    mark = 1'b0;
    discounted_in = 1'b0;
    stolen_in = 1'b0;

    // Reset with scan held high across release: no transaction.
    tick();
    tick();
    reset_n = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    chk("rst_busy",   {7'd0, busy},      8'd0);
    chk("rst_alarm",  {7'd0, alarm},     8'd0);
    chk("rst_upc_q",  {5'd0, upc_q},     8'd0);
    chk("rst_item",   {4'd0, item_cnt},  8'd0);
    chk("rst_disc",   {4'd0, disc_cnt},  8'd0);
    chk("rst_stolen", {4'd0, stolen_cnt}, 8'd0);
    scan_btn = 1'b0;
    tick();

    // Discounted item 101 with mark.
    upc = 3'b101;
    mark = 1'b1;
    discounted_in = 1'b1;
    stolen_in = 1'b0;
    scan_btn = 1'b1;
    tick();                                  // edge 0: captured
    chk("t1_upc_q",  {5'd0, upc_q},  8'h05);
    chk("t1_mark_q", {7'd0, mark_q}, 8'd1);
    chk("t1_busy0",  {7'd0, busy},   8'd1);
    scan_btn = 1'b0;
    upc = 3'b000;                            // switches move; latched code must hold
    tick();                                  // edge 1
    chk("t1_busy1",  {7'd0, busy},   8'd1);
    tick();                                  // edge 2
    chk("t1_busy2",  {7'd0, busy},   8'd1);
    chk("t1_hold",   {5'd0, upc_q},  8'h05);
    chk("t1_item_e2", {4'd0, item_cnt}, 8'd0);
    tick();                                  // edge 3: tallies update
    chk("t1_busy3",  {7'd0, busy},      8'd0);
    chk("t1_item",   {4'd0, item_cnt},  8'd1);
    chk("t1_disc",   {4'd0, disc_cnt},  8'd1);
    chk("t1_last",   {7'd0, last_disc}, 8'd1);

    // New session, then a stolen item.
    new_sess = 1'b1;
    tick();
    new_sess = 1'b0;
    chk("ns_item", {4'd0, item_cnt},  8'd0);
    chk("ns_last", {7'd0, last_disc}, 8'd0);
    upc = 3'b010;
    mark = 1'b0;
    discounted_in = 1'b0;
    stolen_in = 1'b1;
    do_scan();
    chk("st_stolen", {4'd0, stolen_cnt}, 8'd1);
    chk("st_item",   {4'd0, item_cnt},   8'd0);
    chk("st_alarm",  {7'd0, alarm},      8'd1);
    stolen_in = 1'b0;
    for (int i = 0; i < 20; i++) tick();
    chk("st_alarm20", {7'd0, alarm}, 8'd1);
    // Scan and new_sess during alarm are ignored.
    upc = 3'b111;
    scan_btn = 1'b1;
    tick();
    scan_btn = 1'b0;
    new_sess = 1'b1;
    tick();
    new_sess = 1'b0;
    tick();
    tick();
    chk("st_ign_upc",    {5'd0, upc_q},      8'h02);
    chk("st_ign_stolen", {4'd0, stolen_cnt}, 8'd1);
    chk("st_ign_alarm",  {7'd0, alarm},      8'd1);
    // Acknowledge.
    clr_btn = 1'b1;
    tick();
    chk("clr_alarm", {7'd0, alarm}, 8'd0);
    chk("clr_busy",  {7'd0, busy},  8'd0);
    clr_btn = 1'b0;
    tick();

    // Saturation: 17 plain items.
    new_sess = 1'b1;
    tick();
    new_sess = 1'b0;
    discounted_in = 1'b0;
    for (int i = 0; i < 17; i++) do_scan();
    chk("sat_item",   {4'd0, item_cnt},   8'd15);
    chk("sat_disc",   {4'd0, disc_cnt},   8'd0);
    chk("sat_stolen", {4'd0, stolen_cnt}, 8'd0);

    // Three discounted items, then new_sess clears everything.
    new_sess = 1'b1;
    tick();
    new_sess = 1'b0;
    discounted_in = 1'b1;
    for (int i = 0; i < 3; i++) do_scan();
    chk("three_item", {4'd0, item_cnt}, 8'd3);
    chk("three_disc", {4'd0, disc_cnt}, 8'd3);
    new_sess = 1'b1;
    tick();
    new_sess = 1'b0;
    chk("clr3_item", {4'd0, item_cnt},  8'd0);
    chk("clr3_disc", {4'd0, disc_cnt},  8'd0);
    chk("clr3_last", {7'd0, last_disc}, 8'd0);

    // Scan and new_sess together: scan wins.
    do_scan();
    chk("both_pre", {4'd0, item_cnt}, 8'd1);
    scan_btn = 1'b1;
    new_sess = 1'b1;
    tick();
    scan_btn = 1'b0;
    new_sess = 1'b0;
    chk("both_busy", {7'd0, busy},     8'd1);
    chk("both_keep", {4'd0, item_cnt}, 8'd1);
    tick();
    tick();
    tick();
    chk("both_item", {4'd0, item_cnt}, 8'd2);
    chk("both_disc", {4'd0, disc_cnt}, 8'd2);

    // Reset during SETTLE.
    new_sess = 1'b1;
    tick();
    new_sess = 1'b0;
    upc = 3'b110;
    scan_btn = 1'b1;
    tick();
    scan_btn = 1'b0;
    chk("mid_upc", {5'd0, upc_q}, 8'h06);
    reset_n = 1'b0;
    tick();
    chk("mid_busy", {7'd0, busy},     8'd0);
    chk("mid_upc0", {5'd0, upc_q},    8'd0);
    chk("mid_item", {4'd0, item_cnt}, 8'd0);
    reset_n = 1'b1;
    tick();
    tick();
    tick();
    chk("mid_idle", {7'd0, busy},     8'd0);
    chk("mid_cnt",  {4'd0, item_cnt}, 8'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule : tb_upc_checkout_ctrl

// File: doc/upc_checkout_ctrl.md
Name: upc_checkout_ctrl

Overview:
Sequencing controller for the combinational UPC checker (3-bit UPC + mark in, discounted/stolen out) on DE1_SoC. It converts the operator's scan and clear buttons into single transactions, latches the item code, drives it to the checker and waits a settle window. It then samples the verdict, keeps per-session tallies and latches a theft alarm until it is acknowledged. It sits between the switch/KEY inputs and the UPC checker, seg7 display and LEDR.

Parameters:
SETTLE_CYCLES, 2, cycles held in SETTLE before the checker outputs are sampled (legal range 1..15)
CNT_W, 4, width of every tally counter

Ports:
clk  input  1  system clock
reset_n  input  1  synchronous, active-low reset
scan_btn  input  1  scan request, active-high level, already synchronized and debounced
clr_btn  input  1  alarm acknowledge, active-high level, already synchronized
new_sess  input  1  clears tallies; honoured only in IDLE
upc  input  3  item code from SW[9:7]
mark  input  1  security mark from SW[0]
discounted_in  input  1  verdict from the UPC checker
stolen_in  input  1  verdict from the UPC checker
upc_q  output  3  latched code driven to the UPC checker and seg7
mark_q  output  1  latched mark driven to the UPC checker
busy  output  1  high in every state except IDLE
alarm  output  1  high in ALARM
last_disc  output  1  verdict of the last item accepted
item_cnt  output  CNT_W  accepted (non-stolen) items
disc_cnt  output  CNT_W  accepted discounted items
stolen_cnt  output  CNT_W  stolen detections

Behaviour:
- Interface: one clock, clk. Reset reset_n is synchronous, active-low and sampled on the rising clk edge.
- Reset values:
  - state = IDLE.
  - upc_q, mark_q, last_disc, all counters = 0; alarm = 0, busy = 0.
  - scan_prev and clr_prev reset to 1, so a button held through reset release produces no edge.
- Edge detect: scan_edge = scan_btn & ~scan_prev, and clr_edge likewise. The prev registers update every cycle.
- States: IDLE, SETTLE, DECIDE, ALARM.
- IDLE:
  - On scan_edge: upc_q <= upc, mark_q <= mark, settle counter <= 0, go to SETTLE.
  - Else if new_sess: clear all three counters and last_disc.
  - scan_edge and new_sess in the same cycle: the scan wins and new_sess is ignored.
- SETTLE:
  - Increment the settle counter each cycle.
  - Go to DECIDE when counter == SETTLE_CYCLES-1, so SETTLE lasts exactly SETTLE_CYCLES cycles.
  - upc_q and mark_q are stable for the whole transaction.
- DECIDE (one cycle): sample discounted_in and stolen_in.
  - If stolen_in: stolen_cnt++ and go to ALARM; item_cnt, disc_cnt and last_disc are unchanged.
  - Else: item_cnt++, disc_cnt += discounted_in, last_disc <= discounted_in, go to IDLE.
- ALARM: alarm = 1. On clr_edge go to IDLE, and alarm is 0 from the next cycle.
- Latency: from the edge capturing the scan, the counters update at edge SETTLE_CYCLES+1, i.e. 3 edges for the default.
- Counters saturate at 2^CNT_W-1; they never wrap.
- Events ignored while busy:
  - scan_edge in SETTLE, DECIDE or ALARM is dropped, not queued.
  - clr_edge outside ALARM is ignored.
  - new_sess outside IDLE is ignored.
- Reset mid-transaction returns to the full reset state on the same edge; no partial count is kept.
- The controller does not evaluate UPC rules; all verdicts come from the checker ports.

Decomposition:
- Package upc_ctrl_pkg holds the state typedef (enum logic [1:0] {IDLE, SETTLE, DECIDE, ALARM}).
- Sub-module edge_det: registered rising-edge detector, prev reset to 1, instantiated twice (scan and clear).
- Counter saturation is inline logic.
- The top level instantiates this block with the UPC checker inputs connected to upc_q/mark_q. Tallies go to LEDR and the last UPC to seg7.

Test Plan:
- Reset release with scan_btn held high -> no transaction; busy=0, all counters 0 after 5 cycles.
- upc=3'b101, mark=1, scan pulse; bench checker drives discounted_in=1, stolen_in=0 -> upc_q=101 on the next edge; busy high for 3 cycles; item_cnt=1, disc_cnt=1, last_disc=1 at edge 3.
- Scan with stolen_in=1 -> stolen_cnt=1, item_cnt=0, alarm=1 held for 20 cycles; a second scan edge is ignored; clr_edge -> alarm=0, state IDLE.
- 17 non-stolen scans with discounted_in=0 (CNT_W=4) -> item_cnt saturates at 15, disc_cnt=0.
- new_sess in IDLE after 3 items -> all counters 0. Scan_edge and new_sess in the same cycle -> scan accepted and counters not cleared.
- reset_n low during SETTLE -> on the next edge state IDLE, upc_q=0, counters unchanged from 0.
